wave_render: RTL and testbench

WAVE_RENDER -- requirements
Module: wave_render

---
 rtl/wave_render_pkg.sv | 29 ++
 rtl/wave_ram.sv | 30 +++
 rtl/wave_render.sv | 172 +++++++++++++++++
 tb/tb_wave_render.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_render_pkg.sv
// Shared types and constants for the waveform capture/render slice.
// Used by wave_render and wave_ram.
package wave_render_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int H_ACTIVE     = 800;
  localparam int V_ACTIVE     = 600;
  localparam int Y_OFFSET     = 428;
  localparam int AUTO_MAX     = 65535;
  localparam int GRID_X_PITCH = 100;
  localparam int GRID_Y_PITCH = 75;
  localparam int ADDR_W       = 10;

  localparam logic [7:0] COLOR_TRACE = 8'h1C;
  localparam logic [7:0] COLOR_GRID  = 8'h49;
  localparam logic [7:0] COLOR_BG    = 8'h00;

  // Larger samples sit higher on screen; 0x00..0xFF maps to rows 428..173.
  function automatic logic [10:0] sample_to_y(input logic [7:0] s);
    return 11'(Y_OFFSET) - {3'b000, s};
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Two 800-entry sample banks in one simple dual-port RAM with a registered read.
// The bank bit selects the upper or lower half of the storage.
module wave_ram
  import wave_render_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int DEPTH = 2 * H_ACTIVE;

  logic [7:0]  mem [DEPTH];
  logic [10:0] wr_idx;
  logic [10:0] rd_idx;

  assign wr_idx = wr_bank ? 11'(wr_addr) + 11'(H_ACTIVE) : 11'(wr_addr);
  assign rd_idx = rd_bank ? 11'(rd_addr) + 11'(H_ACTIVE) : 11'(rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/wave_render.sv
// Triggered ADC capture into a double-buffered RAM, rendered as an 800x600 trace.
// Define GRID_EN to overlay the graticule on non-trace pixels.
module wave_render
  import wave_render_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  input  logic [7:0]  trig_level,
  input  logic [10:0] x_pos,
  input  logic [10:0] y_pos,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        capturing
);

  cap_state_t        state;
  logic              wr_bank;
  logic              have_frame;
  logic [15:0]       auto_cnt;
  logic [7:0]        prev_sample;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        hs_pipe;
  logic [1:0]        vs_pipe;

  logic              trig_hit;
  logic              auto_hit;
  logic              vsync_fall;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  assign trig_hit   = (prev_sample < trig_level) && (trig_level <= adc_data);
  assign auto_hit   = (auto_cnt == 16'(AUTO_MAX - 1));
  assign vsync_fall = vs_pipe[0] && !vsync_in;
  assign ram_we     = adc_valid && ((state == ARM && (trig_hit || auto_hit)) || state == CAPTURE);
  assign ram_waddr  = (state == CAPTURE) ? wr_addr : '0;
  assign rd_addr    = (x_pos < 11'(H_ACTIVE)) ? x_pos[ADDR_W-1:0] : '0;

  // Capture FSM; DONE is only examined once registered, so a vsync fall coinciding with entry is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_bank     <= 1'b0;
      have_frame  <= 1'b0;
      auto_cnt    <= '0;
      prev_sample <= '0;
      wr_addr     <= '0;
      capturing   <= 1'b0;
    end else begin
      if (adc_valid) prev_sample <= adc_data;
      case (state)
        IDLE: begin
          state     <= ARM;
          capturing <= 1'b1;
          auto_cnt  <= '0;
        end
        ARM: begin
          if (adc_valid) begin
            if (trig_hit || auto_hit) begin
              state    <= CAPTURE;
              wr_addr  <= ADDR_W'(1);
              auto_cnt <= '0;
            end else begin
              auto_cnt <= auto_cnt + 16'd1;
            end
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            if (wr_addr == ADDR_W'(H_ACTIVE - 1)) begin
              state     <= DONE;
              capturing <= 1'b0;
              wr_addr   <= '0;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (vsync_fall) begin
            wr_bank    <= ~wr_bank;
            have_frame <= 1'b1;
            state      <= ARM;
            capturing  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_pipe <= 2'b11;
      vs_pipe <= 2'b11;
    end else begin
      hs_pipe <= {hs_pipe[0], hsync_in};
      vs_pipe <= {vs_pipe[0], vsync_in};
    end
  end

  assign hsync_out = hs_pipe[1];
  assign vsync_out = vs_pipe[1];

  wave_ram u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_bank (wr_bank),
    .wr_addr (ram_waddr),
    .wr_data (adc_data),
    .rd_bank (~wr_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  logic [10:0] x1;
  logic [10:0] y1;
  logic        valid1;
  logic [7:0]  s_prev;
  logic [7:0]  s_left;
  logic [10:0] ty_cur;
  logic [10:0] ty_prev;
  logic [10:0] ty_lo;
  logic [10:0] ty_hi;
  logic        is_trace;
  logic        is_grid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1     <= '0;
      y1     <= '0;
      valid1 <= 1'b0;
      s_prev <= '0;
    end else begin
      x1     <= x_pos;
      y1     <= y_pos;
      valid1 <= valid;
      s_prev <= rd_data;
    end
  end

  // The left column has no neighbour, so it joins the sample to itself.
  assign s_left   = (x1 == 11'd0) ? rd_data : s_prev;
  assign ty_cur   = sample_to_y(rd_data);
  assign ty_prev  = sample_to_y(s_left);
  assign ty_lo    = (ty_cur < ty_prev) ? ty_cur : ty_prev;
  assign ty_hi    = (ty_cur < ty_prev) ? ty_prev : ty_cur;
  assign is_trace = have_frame && (y1 >= ty_lo) && (y1 <= ty_hi);

`ifdef GRID_EN
  assign is_grid = ((x1 % 11'(GRID_X_PITCH)) == 11'd0) || (x1 == 11'(H_ACTIVE - 1)) ||
                   ((y1 % 11'(GRID_Y_PITCH)) == 11'd0) || (y1 == 11'(V_ACTIVE - 1));
`else
  assign is_grid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)        rgb <= COLOR_BG;
    else if (!valid1)  rgb <= COLOR_BG;
    else if (is_trace) rgb <= COLOR_TRACE;
    else if (is_grid)  rgb <= COLOR_GRID;
    else               rgb <= COLOR_BG;
  end

endmodule

// File: tb/tb_wave_render.sv
// Directed bench for wave_render: FSM/capture checks plus a pixel scoreboard.
// Compile with +define+GRID_EN to expect the graticule colour.
module tb_wave_render;
  import wave_render_pkg::*;

`ifdef GRID_EN
  localparam logic [7:0] EXP_GRID = 8'h49;
`else
  localparam logic [7:0] EXP_GRID = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [7:0]  trig_level = 8'h80;
  logic [10:0] x_pos = '0;
  logic [10:0] y_pos = '0;
  logic        valid = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        capturing;

  always #5 clk = ~clk;

  wave_render dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_level (trig_level),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .valid      (valid),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .capturing  (capturing)
  );

  typedef struct {
    int         id;
    logic       chk_rgb;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sb_q[$];
  logic issue = 1'b0;
  logic iss_d1 = 1'b0;
  logic iss_d2 = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   vec_id = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pixel outputs appear two clocks after the vector that produced them.
  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(posedge clk);
      iss_d2 = iss_d1;
      iss_d1 = issue;
      #1;
      if (iss_d2) begin
        if (sb_q.size() == 0) begin
          checkOutput("scoreboard underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          if (e.chk_rgb) checkOutput($sformatf("rgb vec%0d", e.id), int'(rgb), int'(e.rgb));
          checkOutput($sformatf("hsync_out vec%0d", e.id), int'(hsync_out), int'(e.hs));
          checkOutput($sformatf("vsync_out vec%0d", e.id), int'(vsync_out), int'(e.vs));
        end
      end
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input logic v, input logic hs,
                               input logic vs, input logic chk, input logic [7:0] exp_rgb);
    exp_t e;
    @(negedge clk);
    x_pos    = 11'(x);
    y_pos    = 11'(y);
    valid    = v;
    hsync_in = hs;
    vsync_in = vs;
    issue    = 1'b1;
    e.id = vec_id; e.chk_rgb = chk; e.rgb = exp_rgb; e.hs = hs; e.vs = vs;
    sb_q.push_back(e);
    vec_id++;
  endtask

  task automatic drainScoreboard();
    @(negedge clk);
    issue = 1'b0;
    valid = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checkOutput("scoreboard drained", sb_q.size(), 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0; adc_valid = 1'b0; valid = 1'b0; issue = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; trig_level = 8'h80;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    adc_data  = d;
    adc_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic stopStrobes();
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vx[7];
    int vy[7];
    logic vv[7];
    logic [7:0] ve[7];
    fork
      monitorLoop();
    join_none

    // Reset state, with syncs held low so the forced-high outputs are visible.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rgb", int'(rgb), 8'h00);
    checkOutput("reset hsync_out", int'(hsync_out), 1);
    checkOutput("reset vsync_out", int'(vsync_out), 1);
    checkOutput("reset capturing", int'(capturing), 0);
    checkOutput("reset state", int'(dut.state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle->arm state", int'(dut.state), int'(ARM));
    checkOutput("arm capturing", int'(capturing), 1);

    // Grid/background with no frame captured.
    vx = '{100, 5, 101, 799, 10, 100, 0};
    vy = '{5, 75, 76, 10, 599, 5, 0};
    vv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ve = '{EXP_GRID, EXP_GRID, 8'h00, EXP_GRID, EXP_GRID, 8'h00, EXP_GRID};
    for (int i = 0; i < 7; i++)
      applyStimulus(vx[i], vy[i], vv[i], 1'(i % 2), 1'(i / 3), 1'b1, ve[i]);
    drainScoreboard();

    // Ramp capture triggering on 0x80.
    resetDut();
    for (int i = 0; i < 128; i++) strobe(8'(i));
    checkOutput("ramp armed before 0x80", int'(dut.state), int'(ARM));
    strobe(8'h80);
    checkOutput("ramp trigger state", int'(dut.state), int'(CAPTURE));
    checkOutput("ramp addr0", int'(dut.u_ram.mem[0]), 8'h80);
    for (int k = 1; k < 799; k++) strobe(8'(8'h80 + k));
    checkOutput("ramp capturing at 799", int'(capturing), 1);
    strobe(8'(8'h80 + 799));
    checkOutput("ramp done state", int'(dut.state), int'(DONE));
    checkOutput("ramp capturing done", int'(capturing), 0);
    checkOutput("ramp addr799", int'(dut.u_ram.mem[799]), 8'h9F);
    checkOutput("ramp wr_bank", int'(dut.wr_bank), 0);
    stopStrobes();

    // Reset mid-capture at write address 400.
    resetDut();
    strobe(8'h90);
    for (int k = 1; k < 400; k++) strobe(8'h40);
    checkOutput("midcap wr_addr", int'(dut.wr_addr), 400);
    @(negedge clk);
    adc_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midcap hsync_out low", int'(hsync_out), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midcap reset state", int'(dut.state), int'(IDLE));
    checkOutput("midcap wr_bank", int'(dut.wr_bank), 0);
    checkOutput("midcap have_frame", int'(dut.have_frame), 0);
    checkOutput("midcap hsync_out c1", int'(hsync_out), 1);
    checkOutput("midcap vsync_out c1", int'(vsync_out), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midcap hsync_out c2", int'(hsync_out), 1);
    checkOutput("midcap vsync_out c2", int'(vsync_out), 1);
    @(posedge clk); #1;
    checkOutput("midcap hsync_out c3", int'(hsync_out), 0);

    // Auto-trigger on the 65535th non-triggering strobe.
    resetDut();
    for (int i = 0; i < 65534; i++) strobe(8'h10);
    checkOutput("auto still armed", int'(dut.state), int'(ARM));
    strobe(8'h10);
    checkOutput("auto trigger state", int'(dut.state), int'(CAPTURE));
    checkOutput("auto addr0", int'(dut.u_ram.mem[0]), 8'h10);
    strobe(8'h11);
    strobe(8'h11);
    checkOutput("auto wr_addr", int'(dut.wr_addr), 3);
    checkOutput("auto addr1", int'(dut.u_ram.mem[1]), 8'h11);
    stopStrobes();

    // Frame with s[9]=0x00, s[10]=0xFF; DONE coincides with a vsync fall.
    resetDut();
    strobe(8'h90);
    for (int k = 1; k < 799; k++) strobe((k == 9) ? 8'h00 : (k == 10) ? 8'hFF : 8'h40);
    @(negedge clk);
    adc_data = 8'h40; adc_valid = 1'b1; vsync_in = 1'b0;
    @(posedge clk); #1;
    checkOutput("frame done state", int'(dut.state), int'(DONE));
    stopStrobes();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("coincident fall no swap", int'(dut.wr_bank), 0);
    checkOutput("coincident fall no frame", int'(dut.have_frame), 0);
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    vsync_in = 1'b0;
    @(posedge clk); #1;
    checkOutput("swap wr_bank", int'(dut.wr_bank), 1);
    checkOutput("swap have_frame", int'(dut.have_frame), 1);
    checkOutput("swap state", int'(dut.state), int'(ARM));
    checkOutput("swap capturing", int'(capturing), 1);

    applyStimulus(9, 172, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(10, 172, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    applyStimulus(9, 173, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(10, 173, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C);
    applyStimulus(9, 300, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(10, 300, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C);
    applyStimulus(9, 428, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(10, 428, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C);
    applyStimulus(9, 429, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(10, 429, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    applyStimulus(10, 300, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    applyStimulus(10, 200, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(0, 200, 1'b1, 1'b1, 1'b1, 1'b1, EXP_GRID);
    applyStimulus(0, 284, 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C);
    drainScoreboard();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
